sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Two-master arbiter that shares one sram-like memory port between the instruction-fetch side (pre-IF/IF) and the data side (EXE/MEM). It accepts independent req/addr_ok/data_ok transactions from both masters, grants the shared port with fixed data-over-instruction priority, and holds a grant until the slave accepts the address. It records the issuing master of every accepted request in an in-order ID FIFO, so each slave response is steered back to the correct master. It sits between the CPU core and the memory bridge.

## Interface
- OUTSTANDING, 2: maximum accepted-but-unanswered requests on the shared port; legal values 1-4.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- inst_req  in  1  instruction request; held until inst_addr_ok.
- inst_wr  in  1  write flag; always 0 from fetch, forwarded unchanged.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_addr  in  32  request address.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok  out  1  instruction response valid this cycle.
- inst_rdata  out  32  response data, equal to mem_rdata.
- data_req, data_wr, data_size, data_addr, data_wdata  in  1/1/2/32/32  data-side request, same rules as the inst_* inputs.
- data_addr_ok, data_data_ok  out  1/1  data-side handshakes.
- data_rdata  out  32  equal to mem_rdata.
- mem_req, mem_wr  out  1/1  shared-port request and write flag.
- mem_size  out  2  shared-port size.
- mem_addr, mem_wdata  out  32/32  shared-port address and write data.
- mem_addr_ok  in  1  slave accepts mem request.
- mem_data_ok  in  1  slave response valid; responses return in request order.
- mem_rdata  in  32  slave response data.

## Operation
- Arbitration is combinational in the cycle both requests are visible. If data_req=1, data wins; otherwise inst wins.
- Grant lock: if mem_req=1 and mem_addr_ok=0 at a posedge, register lock=1 and lock_src=current source. While locked, the mux selects lock_src regardless of the other master. The lock clears on the cycle mem_addr_ok=1.
- Request mux: mem_wr/size/addr/wdata come from the selected source.
- mem_req = selected source's req AND count<OUTSTANDING. When count==OUTSTANDING, mem_req=0 and both addr_ok outputs are 0.
- inst_addr_ok = mem_addr_ok AND mem_req AND selected==inst. data_addr_ok uses the same rule with selected==data. At most one addr_ok is high per cycle.
- ID FIFO: OUTSTANDING entries of 1 bit each (0=inst, 1=data), plus head/tail pointers and a count of width clog2(OUTSTANDING)+1.
  - Push the source on every accepted handshake (mem_req & mem_addr_ok).
  - Pop the head on mem_data_ok when count>0.
  - Pointers wrap modulo OUTSTANDING.
  - Simultaneous push and pop leaves count unchanged and advances both pointers.
- Response steering:
  - inst_data_ok = mem_data_ok & count>0 & head==0.
  - data_data_ok = mem_data_ok & count>0 & head==1.
  - inst_rdata and data_rdata always equal mem_rdata.
- mem_data_ok with count==0 is a protocol error. It is dropped: no data_ok is raised and the FIFO does not change.
- Reset clears count, pointers, lock and lock_src. Transactions in flight at reset are discarded, and a late mem_data_ok after reset falls under the count==0 drop rule.

## Timing
- Zero-cycle request path: master req to mem_req to mem_addr_ok to master addr_ok, all in the same cycle.
- Zero-cycle response path: mem_data_ok to the steered data_ok in the same cycle.
- The slave asserts data_ok no earlier than the cycle after the matching addr_ok. This guarantees the FIFO entry is present before its response arrives.
- Throughput: one accepted request per cycle while count<OUTSTANDING. A full FIFO that pops in a cycle still blocks a push in that same cycle, because mem_req is computed from the registered count.
- Reset values: count=0, lock=0, mem_req=0, all addr_ok/data_ok=0. mem_wr/size/addr/wdata mirror the inst-side inputs, since inst is selected when no master requests.

## Test plan
- Single inst read: inst_req=1, addr=0xbfc00000, slave addr_ok the same cycle, data_ok 2 cycles later with rdata=0x3c1d0001 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 with inst_rdata=0x3c1d0001 in cycle 2; data_data_ok stays 0.
- Contention: inst_req and data_req both rise in cycle 0, data_addr=0x80001000, slave addr_ok=1 -> mem_addr=0x80001000 and data_addr_ok=1; inst is accepted in cycle 1; responses in cycles 3 and 4 go to data then inst.
- Lock: inst requests at cycle 0 with addr_ok held 0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays the inst address until the inst handshake at cycle 3; data is granted at cycle 4.
- Full FIFO: OUTSTANDING=2, two inst requests accepted with no responses -> mem_req=0 on the third request; one data_ok then frees a slot and the next cycle accepts it.
- Simultaneous push/pop with wrap: stream 6 alternating inst/data requests with one response per cycle -> count stays ≤2, pointers wrap, and each data_ok goes to the correct master in order.
- Reset mid-flight: reset with count=2, followed by a stray mem_data_ok -> no master data_ok, count stays 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the fetch (inst) and data masters.
// Data has fixed priority, grants stay locked until accepted, and responses are steered back in order.
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(OUTSTANDING) + 1;
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [CW-1:0] FULL = CW'(OUTSTANDING);
    localparam logic [PW-1:0] LAST = PW'(OUTSTANDING - 1);
    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    logic          lock;
    logic          lock_src;
    logic          sel;
    logic          sel_req;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          id_fifo [OUTSTANDING];

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A pending (not yet accepted) grant keeps its source even if data arrives meanwhile.
    assign sel     = lock ? lock_src : data_req;
    assign sel_req = (sel == SRC_DATA) ? data_req : inst_req;

    // Gated by the registered count, so a pop never frees a slot for a push in the same cycle.
    assign mem_req   = sel_req && (count != FULL);
    assign mem_wr    = (sel == SRC_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (sel == SRC_DATA) ? data_size  : inst_size;
    assign mem_addr  = (sel == SRC_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (sel == SRC_DATA) ? data_wdata : inst_wdata;

    assign push = mem_req && mem_addr_ok;
    assign pop  = mem_data_ok && (count != '0);

    assign inst_addr_ok = push && (sel == SRC_INST);
    assign data_addr_ok = push && (sel == SRC_DATA);

    // A response with nothing outstanding is dropped: pop is already qualified by count.
    assign inst_data_ok = pop && (id_fifo[head] == SRC_INST);
    assign data_data_ok = pop && (id_fifo[head] == SRC_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock     <= 1'b0;
            lock_src <= SRC_INST;
        end else if (mem_req && !mem_addr_ok) begin
            lock     <= 1'b1;
            lock_src <= sel;
        end else if (push) begin
            lock     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= wrap_inc(tail);
            if (pop)  head <= wrap_inc(head);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the ID storage has no reset; count gates every read, so stale entries are never used.
    always_ff @(posedge clk) begin
        if (push) id_fifo[tail] <= sel;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: reset, single read, contention, lock,
// full FIFO, streaming with wrap, and reset with transactions in flight.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    sram_like_arbiter #(.OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_wdata = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        inst_addr = 32'h1234_5678;
        data_addr = 32'h8765_4321;
        tick(); tick();
        settle();
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'd0);
        check("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'd0);
        check("rst_mem_addr_mirror", mem_addr, 32'h1234_5678);
        reset = 1'b0;
        idle();
        tick();

        // Single instruction read
        inst_req = 1'b1; inst_addr = 32'hbfc0_0000; mem_addr_ok = 1'b1;
        settle();
        check("t1_mem_req", {31'b0, mem_req}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'hbfc0_0000);
        check("t1_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
        check("t1_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        tick();
        idle();
        settle();
        check("t1_c1_inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h3c1d_0001;
        settle();
        check("t1_inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
        check("t1_inst_rdata", inst_rdata, 32'h3c1d_0001);
        check("t1_data_data_ok", {31'b0, data_data_ok}, 32'd0);
        tick();
        idle();

        // Contention: data wins, inst follows next cycle
        inst_req = 1'b1; inst_addr = 32'hbfc0_0004;
        data_req = 1'b1; data_addr = 32'h8000_1000; data_wr = 1'b1;
        data_wdata = 32'hdead_beef; data_size = 2'd1;
        mem_addr_ok = 1'b1;
        settle();
        check("t2_mem_addr_data", mem_addr, 32'h8000_1000);
        check("t2_mem_wr", {31'b0, mem_wr}, 32'd1);
        check("t2_mem_wdata", mem_wdata, 32'hdead_beef);
        check("t2_mem_size", {30'b0, mem_size}, 32'd1);
        check("t2_data_addr_ok", {31'b0, data_addr_ok}, 32'd1);
        check("t2_inst_addr_ok_c0", {31'b0, inst_addr_ok}, 32'd0);
        tick();
        data_req = 1'b0; data_wr = 1'b0;
        settle();
        check("t2_mem_addr_inst", mem_addr, 32'hbfc0_0004);
        check("t2_inst_addr_ok_c1", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        idle();
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111;
        settle();
        check("t2_resp0_data", {30'b0, inst_data_ok, data_data_ok}, 32'b01);
        check("t2_data_rdata", data_rdata, 32'h1111_1111);
        tick();
        mem_rdata = 32'h2222_2222;
        settle();
        check("t2_resp1_inst", {30'b0, inst_data_ok, data_data_ok}, 32'b10);
        tick();
        idle();

        // Lock: inst grant held while addr_ok is low, data waits
        inst_req = 1'b1; inst_addr = 32'hbfc0_0008;
        settle();
        check("t3_c0_mem_req", {31'b0, mem_req}, 32'd1);
        check("t3_c0_inst_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        tick();
        data_req = 1'b1; data_addr = 32'h8000_2000;
        settle();
        check("t3_c1_mem_addr", mem_addr, 32'hbfc0_0008);
        check("t3_c1_data_addr_ok", {31'b0, data_addr_ok}, 32'd0);
        tick();
        settle();
        check("t3_c2_mem_addr", mem_addr, 32'hbfc0_0008);
        tick();
        mem_addr_ok = 1'b1;
        settle();
        check("t3_c3_mem_addr", mem_addr, 32'hbfc0_0008);
        check("t3_c3_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'b10);
        tick();
        inst_req = 1'b0;
        settle();
        check("t3_c4_mem_addr", mem_addr, 32'h8000_2000);
        check("t3_c4_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'b01);
        tick();
        idle();
        mem_data_ok = 1'b1;
        settle();
        check("t3_resp0_inst", {30'b0, inst_data_ok, data_data_ok}, 32'b10);
        tick();
        settle();
        check("t3_resp1_data", {30'b0, inst_data_ok, data_data_ok}, 32'b01);
        tick();
        idle();

        // Full FIFO: third request blocked even while a response pops
        inst_req = 1'b1; inst_addr = 32'h0000_0100; mem_addr_ok = 1'b1;
        settle();
        check("t4_acc0", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        inst_addr = 32'h0000_0104;
        settle();
        check("t4_acc1", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        inst_addr = 32'h0000_0108; mem_data_ok = 1'b1;
        settle();
        check("t4_full_mem_req", {31'b0, mem_req}, 32'd0);
        check("t4_full_addr_ok", {31'b0, inst_addr_ok}, 32'd0);
        check("t4_full_pop", {31'b0, inst_data_ok}, 32'd1);
        tick();
        mem_data_ok = 1'b0;
        settle();
        check("t4_freed_mem_req", {31'b0, mem_req}, 32'd1);
        check("t4_freed_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        idle();
        mem_data_ok = 1'b1;
        settle();
        check("t4_drain0", {30'b0, inst_data_ok, data_data_ok}, 32'b10);
        tick();
        settle();
        check("t4_drain1", {30'b0, inst_data_ok, data_data_ok}, 32'b10);
        tick();
        idle();

        // Stream: inst/data alternate, one response per cycle lagging by one
        for (int k = 0; k <= 6; k++) begin
            idle();
            if (k < 6) begin
                inst_req = (k % 2 == 0); inst_addr = 32'h1000_0000 + k;
                data_req = (k % 2 == 1); data_addr = 32'h2000_0000 + k;
                mem_addr_ok = 1'b1;
            end
            mem_data_ok = (k >= 1);
            mem_rdata = 32'ha000_0000 + k;
            settle();
            if (k < 6) begin
                check($sformatf("t5_addr_ok_%0d", k), {30'b0, inst_addr_ok, data_addr_ok},
                      (k % 2 == 0) ? 32'b10 : 32'b01);
                check($sformatf("t5_mem_addr_%0d", k), mem_addr,
                      (k % 2 == 0) ? 32'h1000_0000 + k : 32'h2000_0000 + k);
            end
            if (k >= 1)
                check($sformatf("t5_data_ok_%0d", k), {30'b0, inst_data_ok, data_data_ok},
                      ((k - 1) % 2 == 0) ? 32'b10 : 32'b01);
            tick();
        end
        idle();

        // Reset with two transactions in flight, then a stray response
        inst_req = 1'b1; inst_addr = 32'h0000_0200; mem_addr_ok = 1'b1;
        tick();
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555;
        settle();
        check("t6_stray_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'b00);
        tick();
        idle();
        inst_req = 1'b1; inst_addr = 32'h0000_0300; mem_addr_ok = 1'b1;
        settle();
        check("t6_post_acc0", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        settle();
        check("t6_post_acc1", {31'b0, inst_addr_ok}, 32'd1);
        tick();
        settle();
        check("t6_post_full", {31'b0, mem_req}, 32'd0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
